mac_operand_sequencer: RTL and testbench
========================================

// Module: mac_operand_sequencer
// PURPOSE
//  Producer end of the MAC operand interface (en/a/b in, acc out).
//  - Buffers one operand vector from an upstream valid/ready load stream.
//  - Replays the vector into the mac datapath, one pair per cycle.
//  - Returns the dot product as (acc_after - acc_before), so no MAC clear is needed.
//  Sits between the matrix controller and a single mac instance.
// PARAMETERS
//  VEC_LEN  4   max pairs per vector (buffer depth, >=1)
//  DATA_W   8   signed operand width
//  ACC_W    32  accumulator / result width
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       asynchronous active-low reset
//  ld_valid   in   1       load beat valid
//  ld_ready   out  1       load beat accepted when valid&ready
//  ld_a       in   DATA_W  signed operand a
//  ld_b       in   DATA_W  signed operand b
//  ld_last    in   1       final pair of this vector
//  mac_en     out  1       MAC enable, one accumulate per high cycle
//  mac_a      out  DATA_W  operand a to MAC
//  mac_b      out  DATA_W  operand b to MAC
//  mac_acc    in   ACC_W   MAC accumulator (registered, updates edge after en)
//  res_valid  out  1       result valid
//  res_ready  in   1       result consumed when valid&ready
//  res_data   out  ACC_W   signed dot product of the vector
//  res_trunc  out  1       vector cut at VEC_LEN (qualified by res_valid)
// BEHAVIOUR
//  Reset (async, any state): state=LOAD, count=0, outputs ld_ready=1,
//   mac_en=0, mac_a=mac_b=0, res_valid=0, res_data=0, res_trunc=0.
//  All outputs registered; mac_a/mac_b held 0 whenever mac_en=0.
//  FSM LOAD -> BASE -> RUN -> DRAIN -> DONE -> LOAD:
//   LOAD : ld_ready=1; each accepted beat writes buf[count], count++.
//          Leave on accepted ld_last, or when the VEC_LEN-th beat is accepted
//          (ld_last=0 there -> trunc=1; ld_last=1 there -> trunc=0).
//          Next vector's beats are not accepted until back in LOAD.
//   BASE : 1 cycle, ld_ready=0; base <= mac_acc. mac_acc is stable because
//          this block owns mac_en.
//   RUN  : count cycles, mac_en=1, mac_a/mac_b = buf[idx], idx 0..count-1.
//          No bubbles between pairs.
//   DRAIN: 1 cycle, mac_en=0; lets the final MAC update land.
//          Then res_data <= mac_acc - base (mod 2^ACC_W), res_trunc <= trunc.
//   DONE : res_valid=1 with res_data/res_trunc stable until res_ready.
//          On handshake -> LOAD, count=0, ld_ready=1 on the next cycle.
//  Latency: last load beat accepted at edge T -> mac_en high at edges T+1..T+N
//   (N = count) -> res_valid rises at edge T+N+2.
//  Arithmetic: the subtraction wraps, so the result is correct even if
//   mac_acc wraps during RUN. res_data is the signed sum of a*b.
//  Boundaries:
//   - Zero-length vector impossible (the first beat always counts).
//   - N=VEC_LEN without trunc is legal.
//   - res_ready held low -> stall indefinitely in DONE; mac_en stays 0.
//   - ld_valid in non-LOAD states is ignored; data is not captured.
//   - Reset mid-RUN drops mac_en the same instant (async). The partial vector
//     and any pending result are discarded.
// STRUCTURE
//  mac_pkg: DATA_W/ACC_W defaults; seq_state_e {LOAD,BASE,RUN,DRAIN,DONE}.
//  Sub-module mac_operand_buf:
//   - VEC_LEN x 2*DATA_W register array.
//   - Write port (we, waddr) and registered read port (raddr).
//   - Read address issued one cycle early, so RUN has no bubble.
// TESTING
//  1. Single beat a=3,b=4,last -> 1 mac_en pulse, res_data=12, trunc=0,
//     res_valid at T+3.
//  2. Back-to-back, no MAC reset: single beat 5,-2 after test 1 ->
//     res_data=-10 (mac_acc=2).
//  3. {1,2,3,4}.{5,6,7,8}, last on 4th beat -> mac_en high 4 consecutive
//     cycles, res_data=70, trunc=0.
//  4. VEC_LEN=4, 6 beats with no last -> 4 beats accepted and ld_ready drops;
//     res_trunc=1; beats 5-6 wait and form the next vector.
//  5. res_ready low 5 cycles -> res_valid/res_data held, ld_ready=0, mac_en=0;
//     then handshake -> ld_ready=1 next cycle.
//  6. a=b=-128 x4 -> res_data=65536.
//     Assert rst_n=0 mid-RUN -> mac_en=0 immediately and ld_ready=1 after release.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg
//   Shared defaults and sequencer state encoding for the MAC operand path.
//   Used by mac_operand_buf and mac_operand_sequencer.
package mac_pkg;

  localparam int VEC_LEN_DEF = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int ACC_W_DEF   = 32;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_BASE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/mac_operand_buf.sv
// mac_operand_buf
//   Holds one operand vector as a DEPTH x WIDTH register array.
//   The read port is registered: rdata shows mem[raddr] one cycle after re,
//   and returns to zero whenever re is low.
// Ports
//   clk, rst_n    clock, asynchronous active-low reset (clears rdata only)
//   we, waddr     write strobe and address
//   wdata         {a, b} operand pair
//   re, raddr     read strobe and address
//   rdata         registered read data
module mac_operand_buf #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Forcing zero when idle keeps the MAC operands at 0 while mac_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
    else         rdata <= '0;
  end

endmodule

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer
//   Buffers one operand vector from a valid/ready load stream, replays it into
//   a MAC one pair per cycle and reports the dot product as the accumulator
//   delta (mac_acc after - mac_acc before), so the MAC is never cleared.
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   ld_valid/ld_ready           load beat handshake
//   ld_a, ld_b, ld_last         operand pair and end-of-vector flag
//   mac_en, mac_a, mac_b        MAC enable and operands (operands 0 when idle)
//   mac_acc                     MAC accumulator, updates the edge after mac_en
//   res_valid/res_ready         result handshake
//   res_data, res_trunc         dot product, vector cut at VEC_LEN
//
// state | meaning
// LOAD  | accept beats into the buffer until ld_last or buffer full
// BASE  | snapshot mac_acc; issue read of pair 0
// RUN   | mac_en high, one pair per cycle, count cycles
// DRAIN | wait for the last accumulate to land, then latch the delta
// DONE  | hold result until res_ready
module mac_operand_sequencer
  import mac_pkg::*;
#(
  parameter int VEC_LEN = VEC_LEN_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACC_W   = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_a,
  input  logic [DATA_W-1:0] ld_b,
  input  logic              ld_last,
  output logic              mac_en,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_trunc
);

  localparam int CW = $clog2(VEC_LEN + 1);
  localparam int AW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  seq_state_e          state, state_next;
  logic [CW-1:0]       count, count_next;
  logic [AW-1:0]       idx, idx_next;
  logic                trunc, trunc_next;
  logic [ACC_W-1:0]    base;
  logic                accept;
  logic                buf_re;
  logic [AW-1:0]       buf_raddr;
  logic [2*DATA_W-1:0] buf_rdata;

  assign accept = ld_valid & ld_ready;

  mac_operand_buf #(
    .DEPTH  (VEC_LEN),
    .WIDTH  (2 * DATA_W),
    .ADDR_W (AW)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept),
    .waddr (count[AW-1:0]),
    .wdata ({ld_a, ld_b}),
    .re    (buf_re),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  assign mac_a = buf_rdata[2*DATA_W-1:DATA_W];
  assign mac_b = buf_rdata[DATA_W-1:0];

  always_comb begin
    state_next = state;
    count_next = count;
    idx_next   = idx;
    trunc_next = trunc;
    buf_re     = 1'b0;
    buf_raddr  = '0;
    case (state)
      ST_LOAD: begin
        if (accept) begin
          count_next = count + CW'(1);
          if (ld_last || (count == CW'(VEC_LEN - 1))) begin
            state_next = ST_BASE;
            trunc_next = ~ld_last;
          end
        end
      end
      ST_BASE: begin
        // Read of pair 0 goes out here so RUN starts without a bubble.
        buf_re     = 1'b1;
        buf_raddr  = '0;
        idx_next   = '0;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        // idx is the pair currently on mac_a/mac_b; prefetch idx+1 if any.
        if (CW'(idx) == count - CW'(1)) begin
          state_next = ST_DRAIN;
        end else begin
          buf_re    = 1'b1;
          buf_raddr = idx + AW'(1);
          idx_next  = idx + AW'(1);
        end
      end
      ST_DRAIN: state_next = ST_DONE;
      ST_DONE: begin
        if (res_ready) begin
          state_next = ST_LOAD;
          count_next = '0;
        end
      end
      default: begin
        state_next = ST_LOAD;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LOAD;
      count     <= '0;
      idx       <= '0;
      trunc     <= 1'b0;
      base      <= '0;
      ld_ready  <= 1'b1;
      mac_en    <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_trunc <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      idx       <= idx_next;
      trunc     <= trunc_next;
      ld_ready  <= (state_next == ST_LOAD);
      mac_en    <= buf_re;
      res_valid <= (state_next == ST_DONE);
      if (state == ST_BASE) base <= mac_acc;
      // Modular subtraction keeps the delta correct across accumulator wrap.
      if (state == ST_DRAIN) begin
        res_data  <= mac_acc - base;
        res_trunc <= trunc;
      end
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
module tb_mac_operand_sequencer;

  localparam int VEC_LEN = 4;
  localparam int DATA_W  = 8;
  localparam int ACC_W   = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_a;
  logic [DATA_W-1:0] ld_b;
  logic              ld_last;
  logic              mac_en;
  logic [DATA_W-1:0] mac_a;
  logic [DATA_W-1:0] mac_b;
  logic [ACC_W-1:0]  mac_acc;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic              res_trunc;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_a [4];
  logic [7:0] exp_b [4];
  int en_cnt, en_first, en_last, valid_at, op_err;

  always #5 clk = ~clk;

  mac_operand_sequencer #(
    .VEC_LEN (VEC_LEN),
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_a      (ld_a),
    .ld_b      (ld_b),
    .ld_last   (ld_last),
    .mac_en    (mac_en),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_acc   (mac_acc),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_trunc (res_trunc)
  );

  // Behavioural MAC: registered accumulator, never cleared except by preset.
  logic signed [15:0] prod;
  logic               preset;
  logic [31:0]        preset_val;
  assign prod = $signed(mac_a) * $signed(mac_b);
  always @(posedge clk) begin
    if (preset)      mac_acc <= preset_val;
    else if (mac_en) mac_acc <= mac_acc + {{16{prod[15]}}, prod};
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached, simulation did not finish");
    $fatal(1);
  end

  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic last);
    int w;
    ld_valid = 1'b1; ld_a = a; ld_b = b; ld_last = last; w = 0;
    while (ld_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w >= 50) begin
      errors++;
      $display("FAIL send_beat_timeout ld_ready=%b expected 1", ld_ready);
    end
    @(negedge clk);
  endtask

  // Observes from the negedge after the last accepted beat (k=0) until res_valid.
  task automatic collect();
    en_cnt = 0; en_first = -1; en_last = -1; valid_at = -1; op_err = 0;
    for (int k = 0; k < 40; k++) begin
      if (mac_en === 1'b1) begin
        if (en_cnt >= 4 || mac_a !== exp_a[en_cnt] || mac_b !== exp_b[en_cnt]) op_err++;
        if (en_first < 0) en_first = k;
        en_last = k;
        en_cnt++;
      end else if (mac_a !== 8'd0 || mac_b !== 8'd0) begin
        op_err++;
      end
      if (res_valid === 1'b1) begin
        valid_at = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_handshake(input string name);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL %s_hs_res_valid got %b expected 0", name, res_valid);
    end
    checks++;
    if (ld_ready !== 1'b1) begin
      errors++; $display("FAIL %s_hs_ld_ready got %b expected 1", name, ld_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ld_valid = 1'b0; ld_a = '0; ld_b = '0; ld_last = 1'b0;
    res_ready = 1'b0; preset = 1'b1; preset_val = 32'd0;
    repeat (3) @(negedge clk);
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready got %b expected 1", ld_ready); end
    checks++; if (mac_en !== 1'b0) begin errors++; $display("FAIL reset_mac_en got %b expected 0", mac_en); end
    checks++; if (mac_a !== 8'd0 || mac_b !== 8'd0) begin errors++; $display("FAIL reset_mac_ab got %h/%h expected 00/00", mac_a, mac_b); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b expected 0", res_valid); end
    checks++; if (res_data !== 32'd0) begin errors++; $display("FAIL reset_res_data got %h expected 0", res_data); end
    checks++; if (res_trunc !== 1'b0) begin errors++; $display("FAIL reset_res_trunc got %b expected 0", res_trunc); end
    rst_n = 1'b1; preset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    exp_a = '{8'd3, 8'd0, 8'd0, 8'd0};
    exp_b = '{8'd4, 8'd0, 8'd0, 8'd0};
    send_beat(8'd3, 8'd4, 1'b1);
    ld_valid = 1'b0;
    collect();
    checks++; if (en_cnt !== 1) begin errors++; $display("FAIL single_en_cnt got %0d expected 1", en_cnt); end
    checks++; if (en_first !== 1) begin errors++; $display("FAIL single_en_first got %0d expected 1", en_first); end
    checks++; if (valid_at !== 3) begin errors++; $display("FAIL single_latency got %0d expected 3", valid_at); end
    checks++; if (op_err !== 0) begin errors++; $display("FAIL single_operands got %0d bad cycles expected 0", op_err); end
    checks++; if (res_data !== 32'd12) begin errors++; $display("FAIL single_res_data got %0d expected 12", $signed(res_data)); end
    checks++; if (res_trunc !== 1'b0) begin errors++; $display("FAIL single_res_trunc got %b expected 0", res_trunc); end
    do_handshake("single");
  endtask

  task automatic test_back_to_back();
    exp_a = '{8'd5, 8'd0, 8'd0, 8'd0};
    exp_b = '{8'hFE, 8'd0, 8'd0, 8'd0};
    send_beat(8'd5, 8'hFE, 1'b1);
    ld_valid = 1'b0;
    collect();
    checks++; if (valid_at !== 3) begin errors++; $display("FAIL b2b_latency got %0d expected 3", valid_at); end
    checks++; if (op_err !== 0) begin errors++; $display("FAIL b2b_operands got %0d bad cycles expected 0", op_err); end
    checks++; if (res_data !== 32'hFFFF_FFF6) begin errors++; $display("FAIL b2b_res_data got %0d expected -10", $signed(res_data)); end
    checks++; if (mac_acc !== 32'd2) begin errors++; $display("FAIL b2b_mac_acc got %0d expected 2", mac_acc); end
    do_handshake("b2b");
  endtask

  task automatic test_vector4();
    exp_a = '{8'd1, 8'd2, 8'd3, 8'd4};
    exp_b = '{8'd5, 8'd6, 8'd7, 8'd8};
    send_beat(8'd1, 8'd5, 1'b0);
    send_beat(8'd2, 8'd6, 1'b0);
    send_beat(8'd3, 8'd7, 1'b0);
    send_beat(8'd4, 8'd8, 1'b1);
    ld_valid = 1'b0;
    collect();
    checks++; if (en_cnt !== 4) begin errors++; $display("FAIL vec4_en_cnt got %0d expected 4", en_cnt); end
    checks++; if (en_first !== 1 || en_last !== 4) begin errors++; $display("FAIL vec4_en_window got %0d..%0d expected 1..4", en_first, en_last); end
    checks++; if (valid_at !== 6) begin errors++; $display("FAIL vec4_latency got %0d expected 6", valid_at); end
    checks++; if (op_err !== 0) begin errors++; $display("FAIL vec4_operands got %0d bad cycles expected 0", op_err); end
    checks++; if (res_data !== 32'd70) begin errors++; $display("FAIL vec4_res_data got %0d expected 70", $signed(res_data)); end
    checks++; if (res_trunc !== 1'b0) begin errors++; $display("FAIL vec4_res_trunc got %b expected 0", res_trunc); end
    do_handshake("vec4");
  endtask

  task automatic test_trunc();
    exp_a = '{8'd1, 8'd1, 8'd1, 8'd1};
    exp_b = '{8'd2, 8'd3, 8'd4, 8'd5};
    send_beat(8'd1, 8'd2, 1'b0);
    send_beat(8'd1, 8'd3, 1'b0);
    send_beat(8'd1, 8'd4, 1'b0);
    send_beat(8'd1, 8'd5, 1'b0);
    // Beat 5 presented while the sequencer is busy; it must wait.
    ld_valid = 1'b1; ld_a = 8'd10; ld_b = 8'd10; ld_last = 1'b0;
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL trunc_ld_ready got %b expected 0", ld_ready); end
    collect();
    checks++; if (en_cnt !== 4) begin errors++; $display("FAIL trunc_en_cnt got %0d expected 4", en_cnt); end
    checks++; if (valid_at !== 6) begin errors++; $display("FAIL trunc_latency got %0d expected 6", valid_at); end
    checks++; if (op_err !== 0) begin errors++; $display("FAIL trunc_operands got %0d bad cycles expected 0", op_err); end
    checks++; if (res_data !== 32'd14) begin errors++; $display("FAIL trunc_res_data got %0d expected 14", $signed(res_data)); end
    checks++; if (res_trunc !== 1'b1) begin errors++; $display("FAIL trunc_res_trunc got %b expected 1", res_trunc); end
    do_handshake("trunc");
    exp_a = '{8'd10, 8'hFD, 8'd0, 8'd0};
    exp_b = '{8'd10, 8'd7, 8'd0, 8'd0};
    send_beat(8'd10, 8'd10, 1'b0);
    send_beat(8'hFD, 8'd7, 1'b1);
    ld_valid = 1'b0;
    collect();
    checks++; if (en_cnt !== 2) begin errors++; $display("FAIL tail_en_cnt got %0d expected 2", en_cnt); end
    checks++; if (valid_at !== 4) begin errors++; $display("FAIL tail_latency got %0d expected 4", valid_at); end
    checks++; if (op_err !== 0) begin errors++; $display("FAIL tail_operands got %0d bad cycles expected 0", op_err); end
    checks++; if (res_data !== 32'd79) begin errors++; $display("FAIL tail_res_data got %0d expected 79", $signed(res_data)); end
    checks++; if (res_trunc !== 1'b0) begin errors++; $display("FAIL tail_res_trunc got %b expected 0", res_trunc); end
    do_handshake("tail");
  endtask

  task automatic test_stall();
    exp_a = '{8'd2, 8'd0, 8'd0, 8'd0};
    exp_b = '{8'd3, 8'd0, 8'd0, 8'd0};
    send_beat(8'd2, 8'd3, 1'b1);
    ld_valid = 1'b0;
    collect();
    checks++; if (valid_at !== 3) begin errors++; $display("FAIL stall_latency got %0d expected 3", valid_at); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== 32'd6 || ld_ready !== 1'b0 || mac_en !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got valid=%b data=%0d ld_ready=%b mac_en=%b expected 1/6/0/0",
                 i, res_valid, res_data, ld_ready, mac_en);
      end
    end
    do_handshake("stall");
  endtask

  task automatic test_wrap();
    preset = 1'b1; preset_val = 32'hFFFF_0000;
    @(negedge clk);
    preset = 1'b0;
    exp_a = '{8'h80, 8'h80, 8'h80, 8'h80};
    exp_b = '{8'h80, 8'h80, 8'h80, 8'h80};
    send_beat(8'h80, 8'h80, 1'b0);
    send_beat(8'h80, 8'h80, 1'b0);
    send_beat(8'h80, 8'h80, 1'b0);
    send_beat(8'h80, 8'h80, 1'b1);
    ld_valid = 1'b0;
    collect();
    checks++; if (en_cnt !== 4) begin errors++; $display("FAIL wrap_en_cnt got %0d expected 4", en_cnt); end
    checks++; if (res_data !== 32'd65536) begin errors++; $display("FAIL wrap_res_data got %0d expected 65536", $signed(res_data)); end
    checks++; if (res_trunc !== 1'b0) begin errors++; $display("FAIL wrap_res_trunc got %b expected 0", res_trunc); end
    do_handshake("wrap");
  endtask

  task automatic test_reset_mid_run();
    send_beat(8'd1, 8'd1, 1'b0);
    send_beat(8'd1, 8'd1, 1'b0);
    send_beat(8'd1, 8'd1, 1'b0);
    send_beat(8'd1, 8'd1, 1'b1);
    ld_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mac_en !== 1'b1) begin errors++; $display("FAIL midrun_pre_mac_en got %b expected 1", mac_en); end
    rst_n = 1'b0;
    #1;
    checks++; if (mac_en !== 1'b0) begin errors++; $display("FAIL midrun_async_mac_en got %b expected 0", mac_en); end
    checks++; if (mac_a !== 8'd0 || mac_b !== 8'd0) begin errors++; $display("FAIL midrun_async_mac_ab got %h/%h expected 00/00", mac_a, mac_b); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL midrun_release_ld_ready got %b expected 1", ld_ready); end
    checks++; if (mac_en !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL midrun_release_idle got mac_en=%b res_valid=%b expected 0/0", mac_en, res_valid); end
    exp_a = '{8'd7, 8'd0, 8'd0, 8'd0};
    exp_b = '{8'd7, 8'd0, 8'd0, 8'd0};
    send_beat(8'd7, 8'd7, 1'b1);
    ld_valid = 1'b0;
    collect();
    checks++; if (en_cnt !== 1 || valid_at !== 3) begin errors++; $display("FAIL midrun_after_timing got en=%0d valid_at=%0d expected 1/3", en_cnt, valid_at); end
    checks++; if (res_data !== 32'd49) begin errors++; $display("FAIL midrun_after_res_data got %0d expected 49", $signed(res_data)); end
    do_handshake("midrun");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_vector4();
    test_trunc();
    test_stall();
    test_wrap();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
